// File: rtl/queue_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : queue_dispatch_scheduler
//  Description : Token-based customer queue. Issues tokens 1..255 on demand
//                (rejecting when MAX_WAIT customers are waiting) and dispatches
//                waiting customers to service counters chosen by a round-robin
//                arbiter over the outstanding counter requests.
//  Revision    : 1.0  initial release
// ============================================================================
module queue_dispatch_scheduler #(
    parameter int NUM_COUNTERS = 8,
    parameter int MAX_WAIT     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_ticket,
    input  logic [NUM_COUNTERS-1:0] counter_req,
    output logic                    ticket_valid,
    output logic [7:0]              ticket_number,
    output logic                    ticket_reject,
    output logic                    serve_valid,
    output logic [2:0]              serve_counter,
    output logic [7:0]              serve_token,
    output logic [2:0]              counter_display,
    output logic [7:0]              customer_number_display,
    output logic [NUM_COUNTERS-1:0] pending_mask,
    output logic [7:0]              waiting_count,
    output logic                    queue_empty,
    output logic                    queue_full
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    logic [7:0]              r_next_ticket;
    logic [7:0]              r_serve_ptr;
    logic [7:0]              r_waiting;
    logic [NUM_COUNTERS-1:0] r_pending;
    logic [2:0]              r_rr_last;

    logic                    w_issue;
    logic                    w_reject;
    logic                    w_dispatch;
    logic                    w_grant_found;
    logic [2:0]              w_grant_idx;
    logic [NUM_COUNTERS-1:0] w_grant_onehot;
    logic [7:0]              w_next_ticket_inc;
    logic [7:0]              w_serve_ptr_inc;
    logic [7:0]              w_waiting_next;

    // Status flags decode the registered occupancy so that same-cycle issue
    // and dispatch decisions both see the state from the previous edge.
    assign queue_empty   = (r_waiting == 8'd0);
    assign queue_full    = (r_waiting == c_max_wait);
    assign waiting_count = r_waiting;
    assign pending_mask  = r_pending;

    assign w_issue    = issue_ticket & ~queue_full;
    assign w_reject   = issue_ticket &  queue_full;
    assign w_dispatch = ~queue_empty & (|r_pending) & w_grant_found;

    // Tokens skip zero: 255 rolls over to 1.
    assign w_next_ticket_inc = (r_next_ticket == 8'd255) ? 8'd1 : r_next_ticket + 8'd1;
    assign w_serve_ptr_inc   = (r_serve_ptr   == 8'd255) ? 8'd1 : r_serve_ptr   + 8'd1;

    // Round-robin search: first pending counter above the last grant, wrapping.
    always_comb begin
        logic [2:0] cand;
        w_grant_found = 1'b0;
        w_grant_idx   = 3'd0;
        for (int k = 1; k <= NUM_COUNTERS; k++) begin
            cand = r_rr_last + 3'(k);
            if (!w_grant_found && r_pending[cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = cand;
            end
        end
    end

    assign w_grant_onehot = w_dispatch ? (NUM_COUNTERS'(1) << w_grant_idx) : '0;

    // Occupancy update; simultaneous issue and dispatch cancel out.
    always_comb begin
        w_waiting_next = r_waiting;
        case ({w_issue, w_dispatch})
            2'b10:   w_waiting_next = r_waiting + 8'd1;
            2'b01:   w_waiting_next = r_waiting - 8'd1;
            default: w_waiting_next = r_waiting;
        endcase
    end

    // Queue state: token pointers, occupancy, pending requests, last grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_ticket <= 8'd1;
            r_serve_ptr   <= 8'd1;
            r_waiting     <= 8'd0;
            r_pending     <= '0;
            r_rr_last     <= 3'd7;
        end else begin
            r_waiting <= w_waiting_next;
            // A request for the counter being granted this cycle is absorbed.
            r_pending <= (r_pending | counter_req) & ~w_grant_onehot;
            if (w_issue) begin
                r_next_ticket <= w_next_ticket_inc;
            end
            if (w_dispatch) begin
                r_serve_ptr <= w_serve_ptr_inc;
                r_rr_last   <= w_grant_idx;
            end
        end
    end

    // Registered event pulses and the held display of the last dispatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ticket_valid            <= 1'b0;
            ticket_number           <= 8'd0;
            ticket_reject           <= 1'b0;
            serve_valid             <= 1'b0;
            serve_counter           <= 3'd0;
            serve_token             <= 8'd0;
            counter_display         <= 3'd0;
            customer_number_display <= 8'd0;
        end else begin
            ticket_valid  <= w_issue;
            ticket_reject <= w_reject;
            serve_valid   <= w_dispatch;
            if (w_issue) begin
                ticket_number <= r_next_ticket;
            end
            if (w_dispatch) begin
                serve_counter           <= w_grant_idx;
                serve_token             <= r_serve_ptr;
                counter_display         <= w_grant_idx;
                customer_number_display <= r_serve_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_dispatch_scheduler
//  Description : Directed self-checking bench for queue_dispatch_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_queue_dispatch_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       issue_ticket = 1'b0;
    logic [7:0] counter_req = 8'd0;
    logic       ticket_valid;
    logic [7:0] ticket_number;
    logic       ticket_reject;
    logic       serve_valid;
    logic [2:0] serve_counter;
    logic [7:0] serve_token;
    logic [2:0] counter_display;
    logic [7:0] customer_number_display;
    logic [7:0] pending_mask;
    logic [7:0] waiting_count;
    logic       queue_empty;
    logic       queue_full;

    int n_cmp = 0;
    int n_err = 0;

    queue_dispatch_scheduler #(.NUM_COUNTERS(8), .MAX_WAIT(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .issue_ticket            (issue_ticket),
        .counter_req             (counter_req),
        .ticket_valid            (ticket_valid),
        .ticket_number           (ticket_number),
        .ticket_reject           (ticket_reject),
        .serve_valid             (serve_valid),
        .serve_counter           (serve_counter),
        .serve_token             (serve_token),
        .counter_display         (counter_display),
        .customer_number_display (customer_number_display),
        .pending_mask            (pending_mask),
        .waiting_count           (waiting_count),
        .queue_empty             (queue_empty),
        .queue_full              (queue_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, then settle just after it.
    task automatic cyc(input logic iss, input logic [7:0] req);
        issue_ticket = iss;
        counter_req  = req;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        issue_ticket = 1'b0;
        counter_req  = 8'd0;
        reset        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nr, bad, zeros, t256, s257;
        logic [7:0] exp_t, exp_s;

        // ---------------- reset state ----------------
        @(posedge clk);
        #1;
        chk("rst_waiting", waiting_count, 0);
        chk("rst_empty", queue_empty, 1);
        chk("rst_full", queue_full, 0);
        chk("rst_pulses", {ticket_valid, ticket_reject, serve_valid}, 0);
        chk("rst_pending", pending_mask, 0);
        chk("rst_disp", {counter_display, customer_number_display}, 0);
        chk("rst_serve", {serve_counter, serve_token}, 0);
        reset = 1'b1;

        // ---------------- basic issue / serve ----------------
        cyc(1'b1, 8'h00);
        chk("basic_tv1", ticket_valid, 1);
        chk("basic_tn1", ticket_number, 1);
        cyc(1'b1, 8'h00);
        chk("basic_tn2", ticket_number, 2);
        cyc(1'b1, 8'h00);
        chk("basic_tn3", ticket_number, 3);
        chk("basic_wait3", waiting_count, 3);
        cyc(1'b0, 8'h20);
        chk("basic_tv_low", ticket_valid, 0);
        chk("basic_no_serve_yet", serve_valid, 0);
        chk("basic_pending", pending_mask, 8'h20);
        cyc(1'b0, 8'h00);
        chk("basic_sv", serve_valid, 1);
        chk("basic_sc", serve_counter, 5);
        chk("basic_st", serve_token, 1);
        chk("basic_wait2", waiting_count, 2);
        chk("basic_pend_clr", pending_mask, 0);
        cyc(1'b0, 8'h00);
        chk("basic_sv_low", serve_valid, 0);
        chk("basic_disp_hold", {counter_display, customer_number_display}, {3'd5, 8'd1});

        // ---------------- round robin ----------------
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h00);
        cyc(1'b0, 8'hFF);
        chk("rr_no_serve", serve_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00);
            chk("rr_sv", serve_valid, 1);
            chk("rr_counter", serve_counter, i);
            chk("rr_token", serve_token, i + 1);
        end
        cyc(1'b0, 8'h00);
        chk("rr_stop", serve_valid, 0);
        chk("rr_pending", pending_mask, 8'hF0);
        chk("rr_empty", queue_empty, 1);

        // ---------------- full / reject ----------------
        do_reset();
        nv = 0;
        nr = 0;
        for (int i = 0; i < 33; i++) begin
            cyc(1'b1, 8'h00);
            nv += int'(ticket_valid);
            nr += int'(ticket_reject);
        end
        chk("full_valid_cnt", nv, 32);
        chk("full_reject_cnt", nr, 1);
        chk("full_flag", queue_full, 1);
        chk("full_wait", waiting_count, 32);
        cyc(1'b1, 8'h01);
        chk("full_rej_a", {ticket_reject, ticket_valid, serve_valid}, 3'b100);
        cyc(1'b1, 8'h00);
        chk("full_rej_b", {ticket_reject, ticket_valid}, 2'b10);
        chk("full_serve", serve_valid, 1);
        chk("full_serve_tok", serve_token, 1);
        chk("full_wait31", waiting_count, 31);

        // ---------------- token wrap ----------------
        do_reset();
        bad = 0;
        zeros = 0;
        t256 = 0;
        s257 = 0;
        exp_t = 8'd1;
        exp_s = 8'd1;
        for (int c = 1; c <= 257; c++) begin
            cyc(1'b1, 8'hFF);
            if (!ticket_valid || ticket_number !== exp_t) bad++;
            if (ticket_number == 8'd0) zeros++;
            exp_t = (exp_t == 8'd255) ? 8'd1 : exp_t + 8'd1;
            if (c >= 2) begin
                if (!serve_valid || serve_token !== exp_s) bad++;
                if (serve_token == 8'd0) zeros++;
                exp_s = (exp_s == 8'd255) ? 8'd1 : exp_s + 8'd1;
            end
            if (c == 256) t256 = int'(ticket_number);
            if (c == 257) s257 = int'(serve_token);
        end
        chk("wrap_seq_errors", bad, 0);
        chk("wrap_zero_seen", zeros, 0);
        chk("wrap_ticket_256", t256, 1);
        chk("wrap_serve_256", s257, 1);

        // ---------------- empty race ----------------
        do_reset();
        cyc(1'b0, 8'h04);
        chk("race_pending", pending_mask, 8'h04);
        cyc(1'b1, 8'h00);
        chk("race_tv", ticket_valid, 1);
        chk("race_no_serve", serve_valid, 0);
        cyc(1'b0, 8'h00);
        chk("race_serve", {serve_valid, serve_counter, serve_token}, {1'b1, 3'd2, 8'd1});
        chk("race_wait", waiting_count, 0);

        // ---------------- asynchronous reset ----------------
        do_reset();
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h02);
        cyc(1'b1, 8'h00);
        chk("async_pre_tv", ticket_valid, 1);
        chk("async_pre_sv", serve_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_wait", waiting_count, 0);
        chk("async_pulses", {ticket_valid, ticket_reject, serve_valid}, 0);
        chk("async_pending", pending_mask, 0);
        chk("async_disp", {counter_display, customer_number_display}, 0);
        issue_ticket = 1'b0;
        counter_req  = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 8'h00);
        chk("async_first_tok", ticket_number, 1);
        chk("async_after_wait", waiting_count, 1);
        chk("async_after_sv", serve_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
